data_mem_resp: RTL and testbench

- Data-memory responder: the far end of the MemRead/MemWr interface driven by the core's control decoder.
- Services one load or store at a time with a fixed multi-cycle latency and stalls the core while busy.
- Handles byte, halfword and word sizes using funct3, including write byte-masking and load sign/zero extension.
- Sits between the datapath ALU result/rs2 and the writeback mux (MemtoReg=1 path).

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_align.sv | 49 ++++
 rtl/data_mem_resp.sv | 121 ++++++++++++
 tb/tb_data_mem_resp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: funct3 codes, FSM states, latched request.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    // K_BAD marks a request with both MemRead and MemWr high; it is never performed.
    typedef enum logic [1:0] {K_LOAD, K_STORE, K_BAD} kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/mem_align.sv
// Size/alignment helper: byte enables and replicated store data, load lane extraction
// with sign/zero extension, and the alignment check. Purely combinational.
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] load_ext,
    output logic        misaligned
);

    logic [31:0] shifted;

    assign shifted = word >> {addr, 3'b000};

    // Decode size from funct3; illegal codes and unaligned addresses enable nothing.
    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        wword      = wdata;
        load_ext   = 32'h0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en  = 4'b0001 << addr;
                wword    = {4{wdata[7:0]}};
                load_ext = funct3[2] ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                misaligned = addr[0];
                byte_en    = addr[0] ? 4'b0000 : (addr[1] ? 4'b1100 : 4'b0011);
                wword      = {2{wdata[15:0]}};
                load_ext   = funct3[2] ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                misaligned = (addr != 2'b00);
                byte_en    = misaligned ? 4'b0000 : 4'b1111;
                load_ext   = word;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one load/store at a time, stalls the core for a fixed
// latency, commits stores on the edge into RESP and presents a one-cycle done strobe.
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemRead,
    input  logic        MemWr,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    req_t        in_req, sel;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          req_any, commit, we, al_mis;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word, wword, load_ext;
    logic [3:0]    byte_en;
    logic          unused_addr_hi;

    assign req_any = MemRead | MemWr;

    // Package the incoming request; the alignment helper sees it directly in IDLE
    // (needed when LATENCY=1 commits on the accepting edge) and the latched copy otherwise.
    always_comb begin
        in_req.kind   = (MemRead & MemWr) ? K_BAD : (MemWr ? K_STORE : K_LOAD);
        in_req.funct3 = funct3;
        in_req.addr   = addr;
        in_req.wdata  = wdata;
        sel           = (state_q == IDLE) ? in_req : req_q;
    end

    // Higher address bits alias onto the array.
    assign idx            = sel.addr[AW+1:2];
    assign unused_addr_hi = ^sel.addr[31:AW+2];
    assign rd_word        = mem_q[idx];

    mem_align u_align (
        .funct3     (sel.funct3),
        .addr       (sel.addr[1:0]),
        .wdata      (sel.wdata),
        .word       (rd_word),
        .byte_en    (byte_en),
        .wword      (wword),
        .load_ext   (load_ext),
        .misaligned (al_mis)
    );

    // Next-state: latch in IDLE, count down in WAIT, single RESP cycle back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    req_d = in_req;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // A store commits on the edge entering RESP, unless reset is asserted on that edge.
    assign commit = (state_q == WAIT && cnt_q == 4'd1) ||
                    (LATENCY == 1 && state_q == IDLE && req_any);
    assign we     = commit && sel.kind == K_STORE && !al_mis;

    // Byte-masked array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (n_rst && we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign done       = (state_q == RESP);
    assign stall      = (state_q == WAIT) || (state_q == IDLE && req_any);
    assign misaligned = done && (req_q.kind == K_BAD || al_mis);
    assign rdata      = (done && req_q.kind == K_LOAD && !al_mis) ? load_ext : 32'h0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed cases plus randomized traffic
// against a byte-level reference memory.
module tb_data_mem_resp;

    localparam int LAT   = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        MemRead, MemWr;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, done, misaligned;

    int ncmp = 0;
    int nerr = 0;

    logic [31:0] mdl [DEPTH];

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .MemRead    (MemRead),
        .MemWr      (MemWr),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: apply one access to the byte-level model, return expected rdata/misaligned.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] er, output logic em);
        int w, ln, sz;
        bit sgn;
        logic [31:0] v, mask;
        w  = int'((a >> 2) % DEPTH);
        ln = int'(a % 4);
        er = 32'h0;
        em = 1'b0;
        sz = 0;
        sgn = 1'b0;
        if (rd && wr) begin
            em = 1'b1;
            return;
        end
        case (f3)
            3'd0: begin sz = 1; sgn = 1'b1; end
            3'd1: begin sz = 2; sgn = 1'b1; end
            3'd2: sz = 4;
            3'd4: sz = 1;
            3'd5: sz = 2;
            default: sz = 0;
        endcase
        if (sz == 0 || (ln % sz) != 0) begin
            em = 1'b1;
            return;
        end
        if (wr) begin
            for (int i = 0; i < sz; i++) mdl[w][8*(ln+i) +: 8] = wd[8*i +: 8];
        end else begin
            v    = mdl[w] >> (8 * ln);
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            er   = v & mask;
            if (sgn && v[8*sz-1]) er = er | ~mask;
        end
    endfunction

    // Issue one request from an IDLE cycle (called #1 after a rising edge) and check
    // stall during the wait, latency, and the response. Returns one cycle after done.
    task automatic acc(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] er;
        logic        em;
        int          n;
        bit          got;
        model(rd, wr, f3, a, wd, er, em);
        MemRead = rd; MemWr = wr; funct3 = f3; addr = a; wdata = wd;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                chk({tag, "/stall"}, 32'(stall), 32'd1);
                @(posedge clk);
                #1;
                // Request is latched; scramble inputs to show they are ignored.
                MemRead = 1'b0; MemWr = 1'b0;
                funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
                n++;
            end
        end
        chk({tag, "/done"}, 32'(got), 32'd1);
        if (!(rd && wr)) chk({tag, "/lat"}, 32'(n), 32'(LAT));
        chk({tag, "/rdata"}, rdata, er);
        chk({tag, "/mis"}, 32'(misaligned), 32'(em));
        chk({tag, "/stall0"}, 32'(stall), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dcyc[$];
        int cyc;
        logic [31:0] er;
        logic        em;

        n_rst = 1'b0; MemRead = 1'b0; MemWr = 1'b0;
        funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/stall", 32'(stall), 32'd0);
        chk("rst/rdata", rdata, 32'h0);
        chk("rst/mis", 32'(misaligned), 32'd0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Initialise the working region (words 0..15).
        for (int w = 0; w < 16; w++) acc("init", 1'b0, 1'b1, 3'd2, 32'(w * 4), $urandom);

        acc("sw10",   1'b0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        acc("lw10",   1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        acc("sb13",   1'b0, 1'b1, 3'd0, 32'h13, 32'h80);
        acc("lb13",   1'b1, 1'b0, 3'd0, 32'h13, 32'h0);
        acc("lbu13",  1'b1, 1'b0, 3'd4, 32'h13, 32'h0);
        acc("lw10b",  1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        acc("sh12",   1'b0, 1'b1, 3'd1, 32'h12, 32'h1234);
        acc("lh12",   1'b1, 1'b0, 3'd1, 32'h12, 32'h0);
        acc("lh11",   1'b1, 1'b0, 3'd1, 32'h11, 32'h0);
        acc("sw11",   1'b0, 1'b1, 3'd2, 32'h11, 32'h5555_5555);
        acc("lw10c",  1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        acc("f3_011", 1'b1, 1'b0, 3'd3, 32'h10, 32'h0);
        acc("sw1010", 1'b0, 1'b1, 3'd2, 32'h1010, 32'hCAFE_F00D);
        acc("lw10d",  1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        acc("both",   1'b1, 1'b1, 3'd2, 32'h10, 32'h0BAD_0BAD);
        acc("lw10e",  1'b1, 1'b0, 3'd2, 32'h10, 32'h0);

        // Reset in WAIT discards the store to 0x20.
        MemWr = 1'b1; funct3 = 3'd2; addr = 32'h20; wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        MemWr = 1'b0;
        @(negedge clk);
        chk("rstw/stall", 32'(stall), 32'd1);
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw/done", 32'(done), 32'd0);
        chk("rstw/stall0", 32'(stall), 32'd0);
        n_rst = 1'b1;
        acc("lw20", 1'b1, 1'b0, 3'd2, 32'h20, 32'h0);

        // MemRead held high: back-to-back loads with one IDLE cycle between done pulses.
        model(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, er, em);
        MemRead = 1'b1; MemWr = 1'b0; funct3 = 3'd2; addr = 32'h10;
        for (cyc = 0; cyc <= 3 * LAT + 2; cyc++) begin
            @(negedge clk);
            if (done) begin
                dcyc.push_back(cyc);
                chk("b2b/rdata", rdata, er);
            end
            @(posedge clk);
            #1;
        end
        MemRead = 1'b0;
        chk("b2b/npulse", 32'(dcyc.size()), 32'd3);
        if (dcyc.size() == 3) begin
            chk("b2b/first", 32'(dcyc[0]), 32'(LAT));
            chk("b2b/gap1", 32'(dcyc[1] - dcyc[0]), 32'(LAT + 1));
            chk("b2b/gap2", 32'(dcyc[2] - dcyc[1]), 32'(LAT + 1));
        end

        // Randomized traffic in the working region, with aliased upper address bits.
        for (int i = 0; i < 150; i++) begin
            int r;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2) |
                32'($urandom_range(0, 3));
            if (r == 0)
                acc("rnd_both", 1'b1, 1'b1, 3'($urandom), a, $urandom);
            else if (r < 5)
                acc("rnd_st", 1'b0, 1'b1, 3'($urandom), a, $urandom);
            else
                acc("rnd_ld", 1'b1, 1'b0, 3'($urandom), a, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
